ct_spsram_1024x92_arb_ctrl: RTL

//  Shares one 1024x92 single-port SRAM macro between two requesters (r0, r1).

---
 rtl/ct_spsram_1024x92_arb_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ct_spsram_1024x92_arb_ctrl.sv
// Two-requester round-robin front end for a 1024x92 single-port SRAM macro.
// Registers one SRAM command per cycle, returns reads two cycles after
// acceptance, and zero-fills the array after reset and on clr.
//
// Handshake: a request transfers in the cycle where rN_vld & rN_rdy are both
// high; rN_vld with its payload must hold until that cycle. rN_rdy is
// combinational from the vld inputs, the round-robin pointer, clr and the state.
// Read responses carry no backpressure.
module ct_spsram_1024x92_arb_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 92,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    output logic                  init_done,
    output logic                  state_dbg,
    input  logic                  r0_vld,
    output logic                  r0_rdy,
    input  logic                  r0_wr,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [3:0]            r0_lmask,
    input  logic                  r1_vld,
    output logic                  r1_rdy,
    input  logic                  r1_wr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [3:0]            r1_lmask,
    output logic                  rsp0_vld,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int LANES  = 4;
    localparam int LANE_W = DATA_WIDTH / LANES;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    // One extra bit so the sweep can mark "all DEPTH words written" without
    // wrapping back onto address 0.
    logic [ADDR_WIDTH:0]     sweep_cnt;
    logic                    rr_ptr;     // 0: r0 wins a tie, 1: r1 wins a tie
    logic                    grant0;
    logic                    grant1;
    logic                    accept;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [3:0]              sel_lmask;
    logic [DATA_WIDTH-1:0]   sel_wen;
    logic                    rd_pend0;
    logic                    rd_pend1;

    assign state_dbg = (state == ST_RUN);
    assign r0_rdy    = grant0;
    assign r1_rdy    = grant1;
    assign accept    = grant0 | grant1;
    assign rsp_data  = sram_q;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN && !clr && !RST) begin
            if (r0_vld && r1_vld) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = r0_vld;
                grant1 = r1_vld;
            end
        end
    end

    // Select the granted request's payload and expand its lane mask to bit enables.
    always_comb begin
        sel_wr    = grant1 ? r1_wr    : r0_wr;
        sel_addr  = grant1 ? r1_addr  : r0_addr;
        sel_wdata = grant1 ? r1_wdata : r0_wdata;
        sel_lmask = grant1 ? r1_lmask : r0_lmask;
        sel_wen   = '1;
        for (int k = 0; k < LANES; k++) begin
            sel_wen[k*LANE_W +: LANE_W] = {LANE_W{~sel_lmask[k]}};
        end
    end

    // Main FSM: zero-fill sweep in INIT, registered SRAM command stage in RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= INIT_EN ? ST_INIT : ST_RUN;
            init_done <= !INIT_EN;
            sweep_cnt <= '0;
            rr_ptr    <= 1'b0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            case (state)
                ST_INIT: begin
                    if (sweep_cnt[ADDR_WIDTH]) begin
                        // Last word (DEPTH-1) was issued last cycle.
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                        sweep_cnt <= '0;
                    end else begin
                        sram_cen  <= 1'b0;
                        sram_gwen <= 1'b0;
                        sram_wen  <= '0;
                        sram_a    <= sweep_cnt[ADDR_WIDTH-1:0];
                        sram_d    <= '0;
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state     <= ST_INIT;
                        init_done <= 1'b0;
                        sweep_cnt <= '0;
                    end
                    if (accept) begin
                        rr_ptr <= grant0;
                        sram_a <= sel_addr;
                        if (!sel_wr) begin
                            sram_cen <= 1'b0;
                        end else begin
                            sram_d <= sel_wdata;
                            // An all-zero lane mask completes the handshake but touches nothing.
                            if (|sel_lmask) begin
                                sram_cen  <= 1'b0;
                                sram_gwen <= 1'b0;
                                sram_wen  <= sel_wen;
                            end
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Read return pipeline: command cycle, then data cycle from the macro.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
        end else begin
            rd_pend0 <= grant0 & ~r0_wr;
            rd_pend1 <= grant1 & ~r1_wr;
            rsp0_vld <= rd_pend0;
            rsp1_vld <= rd_pend1;
        end
    end

endmodule
